// File: rtl/divider_8bit.sv
// Unsigned 8-bit sequential restoring divider, one shift-subtract step per clock.
// Dividend enters through Q; the quotient replaces it, so runs can be chained.
module divider_8bit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Ld_D,
    input  logic       Ld_Q,
    input  logic       Run,
    input  logic [7:0] S,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic [7:0] D,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [2:0] cnt;
    logic [8:0] partial;
    logic [8:0] diff;
    logic       fits;

    // Compare at 9 bits; since R < D before every step, the difference fits in 8.
    assign partial = {R, Q[7]};
    assign diff    = partial - {1'b0, D};
    assign fits    = (partial >= {1'b0, D});

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            Q       <= 8'd0;
            R       <= 8'd0;
            D       <= 8'd0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        state   <= CALC;
                        cnt     <= 3'd0;
                        R       <= 8'd0;
                        DivZero <= (D == 8'd0);
                    end else begin
                        if (Ld_D) begin
                            D <= S;
                        end
                        if (Ld_Q) begin
                            Q <= S;
                            R <= 8'd0;
                        end
                    end
                end
                CALC: begin
                    if (fits) begin
                        R <= diff[7:0];
                        Q <= {Q[6:0], 1'b1};
                    end else begin
                        R <= partial[7:0];
                        Q <= {Q[6:0], 1'b0};
                    end
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!Run) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Busy = (state == CALC);
    assign Done = (state == DONE);

endmodule

// File: doc/divider_8bit.md
# divider_8bit

Unsigned 8-bit sequential restoring divider, the division counterpart of the shift-add multiplier datapath. Divisor and dividend are loaded from the shared 8-bit switch bus `S`. A `Run` pulse computes quotient and remainder with one shift-subtract iteration per clock. Results stay on `Q`/`R` for display until the next load or run. The quotient register remains the dividend source, so divisions can be chained.

## Interface
Parameters: none; width fixed at 8.

- `Clk`  in  1  clock; all state changes on the rising edge
- `Reset`  in  1  reset: synchronous, active-high
- `Ld_D`  in  1  load divisor register from `S`; acted on in IDLE only
- `Ld_Q`  in  1  load dividend into `Q` from `S`, and clear `R`; acted on in IDLE only
- `Run`  in  1  start a division; level-sampled
- `S`  in  8  switch / data bus
- `Q`  out  8  quotient register (holds the dividend before a run)
- `R`  out  8  remainder register
- `D`  out  8  divisor register
- `Busy`  out  1  high while in CALC
- `Done`  out  1  high while in DONE
- `DivZero`  out  1  set when the current or last run used `D == 0`

## Operation
- States:
  - IDLE: waits for a run.
  - CALC: 8 iterations, tracked by a 3-bit counter `cnt`.
  - DONE: holds until `Run` is released.
- IDLE, each edge, by priority:
  - `Run=1` → state CALC, `cnt<=0`, `R<=0`, `DivZero<=(D==0)`; any `Ld_D`/`Ld_Q` in the same cycle is ignored.
  - Otherwise, `Ld_D` → `D<=S`.
  - `Ld_Q` → `Q<=S`, `R<=0`.
  - `Ld_D` and `Ld_Q` may both act in the same cycle.
- CALC, each edge, one iteration:
  - `P = {R, Q[7]}` (9 bits).
  - If `P >= {1'b0, D}`: `R <= (P - D)[7:0]` and `Q <= {Q[6:0], 1'b1}`.
  - Else: `R <= P[7:0]` and `Q <= {Q[6:0], 1'b0}`.
  - `cnt <= cnt + 1`.
  - When `cnt == 7`, state goes to DONE.
- Width rule: the invariant `R < D` holds before each iteration, so `P < 2D` and `P - D` always fits in 8 bits. The comparison must be done at 9 bits.
- Divide by zero: no special path. The algorithm runs all 8 iterations and yields `Q=8'hFF`, `R=dividend`. `DivZero=1` flags the result.
- DONE:
  - `Run=1` → stay in DONE.
  - `Run=0` → IDLE next edge.
  - `Q`, `R`, `D` and `DivZero` are retained.
- Chaining: from IDLE, a new `Run` without `Ld_Q` divides the current `Q` by `D`.
- `Ld_D`, `Ld_Q` and `Run` are ignored in CALC. `Ld_D` and `Ld_Q` are also ignored in DONE.
- `Reset` in any state (including mid-CALC): next edge → IDLE, with `Q`, `R`, `D`, `cnt`, `DivZero` all 0. A reset mid-operation produces no partial-result retention.

## Timing
- Reset values: `Q=0`, `R=0`, `D=0`, `Busy=0`, `Done=0`, `DivZero=0`, state IDLE.
- Call the edge that samples `Run=1` in IDLE E0.
  - `Busy=1` after E0.
  - Iterations happen on E1..E8.
  - After E8: `Busy=0`, `Done=1`, and `Q`/`R` are final.
  - Total latency: 9 edges from the sampling edge to a valid result.
- `Done` stays high as long as `Run` stays high. `Done` falls one edge after `Run` is sampled low.
- The earliest next start is the edge after returning to IDLE, i.e. `Run` must be low for at least one sampled edge.
- Loads take effect at the edge where they are sampled, and are visible on the outputs in the next cycle.
- `Busy`, `Done` and `DivZero` are decoded from registered state, with no combinational path from inputs.

## Test plan
- Load `D=7`, `Q=200`, pulse `Run` → after 9 edges `Q=28`, `R=4`, `Done=1`, `DivZero=0`. `Busy` must be high for exactly 8 cycles.
- Chain: keep `D=7`, release then re-assert `Run` without a load → `Q=4`, `R=0`.
- Edge values:
  - `255/1` → `Q=255`, `R=0`.
  - `5/9` → `Q=0`, `R=5`.
  - `255/255` → `Q=1`, `R=0`.
  - `0/3` → `Q=0`, `R=0`.
- Divide by zero: `D=0`, `Q=100`, `Run` → `Q=8'hFF`, `R=100`, `DivZero=1`, same 9-edge latency.
- Assert `Reset` on the 4th CALC edge → next cycle all outputs 0, state IDLE. A subsequent load-and-run of `200/7` still gives `28 r 4`.
- Assert `Ld_Q`/`Ld_D` with `S=8'h55` during CALC and during DONE → no change to `Q`/`R`/`D`. Hold `Run` high for 20 cycles after `Done` → `Done` stays high with no restart. Assert `Run` and `Ld_Q` together in IDLE → run starts using the old `Q`.
